mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto a single memory port with starvation guard and timeout
// Ports:
//   SYS_clk, SYS_reset_n                      clock, synchronous active-low reset
//   if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//                                             fetch requester
//   dm_req, dm_we, dm_len, dm_signed, dm_addr, dm_wdata -> dm_gnt, dm_rvalid, dm_rdata
//                                             data requester
//   mem_req, mem_we, mem_len, mem_signed, mem_addr, mem_wdata <- mem_ack, mem_rdata
//                                             memory port
//   bus_error                                 sticky timeout flag
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_len,
  input  logic        dm_signed,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_len,
  output logic        mem_signed,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  // Last WAIT cycle index before the counter would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IF = 2'd1,
    S_WAIT_DM = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          w_grant_if;
  logic          w_grant_dm;
  logic          w_ack;
  logic          w_expire;
  logic          w_finish;
  logic          w_if_wins;

  logic [SW-1:0] r_streak;
  logic [CW-1:0] r_wait_cnt;
  logic          r_we;
  logic [1:0]    r_len;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_if_gnt;
  logic          r_dm_gnt;
  logic          r_if_rvalid;
  logic          r_dm_rvalid;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_dm_rdata;
  logic          r_bus_error;

  // Fetch only beats a pending data request once data has had its full streak.
  assign w_if_wins = if_req && (!dm_req || (r_streak == STREAK_MAX));

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_ack      = 1'b0;
    w_expire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_if_wins) begin
          w_grant_if = 1'b1;
          w_next     = S_WAIT_IF;
        end else if (dm_req) begin
          w_grant_dm = 1'b1;
          w_next     = S_WAIT_DM;
        end
      end
      S_WAIT_IF, S_WAIT_DM: begin
        // An ack on the final allowed cycle still completes normally.
        if (mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_finish = w_ack || w_expire;

    mem_req    = (r_state != S_IDLE);
    mem_we     = mem_req ? r_we     : 1'b0;
    mem_len    = mem_req ? r_len    : 2'b00;
    mem_signed = mem_req ? r_signed : 1'b0;
    mem_addr   = mem_req ? r_addr   : 32'h0;
    mem_wdata  = mem_req ? r_wdata  : 32'h0;
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      r_streak    <= '0;
      r_wait_cnt  <= '0;
      r_we        <= 1'b0;
      r_len       <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_dm_rdata  <= 32'h0;
      r_bus_error <= 1'b0;
    end else begin
      r_if_gnt    <= w_grant_if;
      r_dm_gnt    <= w_grant_dm;
      r_if_rvalid <= w_finish && (r_state == S_WAIT_IF);
      r_dm_rvalid <= w_finish && (r_state == S_WAIT_DM);

      if (w_grant_if) begin
        r_we     <= 1'b0;
        r_len    <= 2'b11;
        r_signed <= 1'b0;
        r_addr   <= if_addr;
        r_wdata  <= 32'h0;
        r_streak <= '0;
      end else if (w_grant_dm) begin
        r_we     <= dm_we;
        r_len    <= dm_len;
        r_signed <= dm_signed;
        r_addr   <= dm_addr;
        r_wdata  <= dm_wdata;
        if (r_streak != STREAK_MAX) begin
          r_streak <= r_streak + SW'(1);
        end
      end

      if (w_grant_if || w_grant_dm) begin
        r_wait_cnt <= '0;
      end else if ((r_state != S_IDLE) && !mem_ack) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end

      // Stores and timeouts complete with zero read data.
      if (w_finish) begin
        if (r_state == S_WAIT_IF) begin
          r_if_rdata <= w_ack ? mem_rdata : 32'h0;
        end else begin
          r_dm_rdata <= (w_ack && !r_we) ? mem_rdata : 32'h0;
        end
      end

      if (w_expire) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign dm_gnt    = r_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign bus_error = r_bus_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic        SYS_clk;
  logic        SYS_reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_len;
  logic        dm_signed;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic        mem_signed;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_error;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_len(dm_len), .dm_signed(dm_signed),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .bus_error(bus_error)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_if;
    logic        we;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] ack;
    logic        e_we;
    logic [1:0]  e_len;
    logic        e_sgn;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_berr;
    int          e_waits;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, " if_gnt"}, if_gnt, 1'b0);
    chk1({tag, " dm_gnt"}, dm_gnt, 1'b0);
    chk1({tag, " if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, " dm_rvalid"}, dm_rvalid, 1'b0);
    chk({tag, " if_rdata"}, if_rdata, 32'h0);
    chk({tag, " dm_rdata"}, dm_rdata, 32'h0);
    chk1({tag, " mem_req"}, mem_req, 1'b0);
    chk1({tag, " mem_we"}, mem_we, 1'b0);
    chk({tag, " mem_len"}, 32'(mem_len), 32'h0);
    chk1({tag, " mem_signed"}, mem_signed, 1'b0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk1({tag, " bus_error"}, bus_error, 1'b0);
  endtask

  task automatic do_reset();
    SYS_reset_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    SYS_reset_n = 1'b1;
  endtask

  // Caller drives the requests; the expected winner's request is dropped once granted.
  // delay: WAIT cycles without ack before the ack cycle, or -1 for no ack at all.
  task automatic do_txn(input int tag, input bit win_if, input logic e_we, input logic [1:0] e_len,
                        input logic e_sgn, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input int delay, input logic [31:0] ack, input logic [31:0] e_rdata,
                        input logic e_berr, input int e_waits);
    int waits;
    bit seen;
    tick();
    chk1($sformatf("t%0d if_gnt", tag), if_gnt, win_if);
    chk1($sformatf("t%0d dm_gnt", tag), dm_gnt, !win_if);
    chk1($sformatf("t%0d rvalid_pulse", tag), if_rvalid | dm_rvalid, 1'b0);
    if (win_if) if_req = 1'b0; else dm_req = 1'b0;
    chk1($sformatf("t%0d mem_req", tag), mem_req, 1'b1);
    chk1($sformatf("t%0d mem_we", tag), mem_we, e_we);
    chk($sformatf("t%0d mem_len", tag), 32'(mem_len), 32'(e_len));
    chk1($sformatf("t%0d mem_signed", tag), mem_signed, e_sgn);
    chk($sformatf("t%0d mem_addr", tag), mem_addr, e_addr);
    chk($sformatf("t%0d mem_wdata", tag), mem_wdata, e_wdata);
    waits = 1;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = ack;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (if_rvalid || dm_rvalid) begin
        seen = 1'b1;
      end else begin
        waits++;
        chk1($sformatf("t%0d wait mem_req", tag), mem_req, 1'b1);
        chk($sformatf("t%0d wait mem_addr", tag), mem_addr, e_addr);
        chk1($sformatf("t%0d wait gnt", tag), if_gnt | dm_gnt, 1'b0);
      end
    end
    chk1($sformatf("t%0d completion seen", tag), seen, 1'b1);
    chk($sformatf("t%0d wait cycles", tag), waits, e_waits);
    chk1($sformatf("t%0d if_rvalid", tag), if_rvalid, win_if);
    chk1($sformatf("t%0d dm_rvalid", tag), dm_rvalid, !win_if);
    chk($sformatf("t%0d rdata", tag), win_if ? if_rdata : dm_rdata, e_rdata);
    chk1($sformatf("t%0d bus_error", tag), bus_error, e_berr);
    chk1($sformatf("t%0d idle mem_req", tag), mem_req, 1'b0);
    chk($sformatf("t%0d idle mem_addr", tag), mem_addr, 32'h0);
    chk($sformatf("t%0d idle mem_wdata", tag), mem_wdata, 32'h0);
    chk($sformatf("t%0d idle mem_len", tag), 32'(mem_len), 32'h0);
  endtask

  // Reference state for the randomized phase.
  bit          if_pend, dm_pend, win_if, tmo;
  int          streak_m, delay, r;
  logic [31:0] m_if_rdata, m_dm_rdata, ack, e_rdata;
  logic        m_berr;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h100,  32'h0,        0,  32'h11112222,
                1'b0, 2'b11, 1'b0, 32'h0,        32'h11112222, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 1'b1, 32'h104,  32'hDEADBEEF, 2,  32'h33334444,
                1'b0, 2'b11, 1'b0, 32'h0,        32'h33334444, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h2000, 32'h0,        1,  32'hCAFE0001,
                1'b0, 2'b11, 1'b0, 32'h0,        32'hCAFE0001, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h13,   32'hAB,       3,  32'h55555555,
                1'b1, 2'b01, 1'b0, 32'hAB,       32'h0,        1'b0, 4};
    vecs[4] = '{1'b0, 1'b0, 2'b10, 1'b1, 32'h22,   32'h12345678, 0,  32'h0000FFFF,
                1'b0, 2'b10, 1'b1, 32'h12345678, 32'h0000FFFF, 1'b0, 1};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h200,  32'h0,        7,  32'hA5A5A5A5,
                1'b0, 2'b11, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 8};
    vecs[6] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h3000, 32'h0,        -1, 32'h77777777,
                1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 8};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h300,  32'h0,        0,  32'h9999AAAA,
                1'b0, 2'b11, 1'b0, 32'h0,        32'h9999AAAA, 1'b1, 1};

    if_addr = 32'h0; dm_we = 1'b0; dm_len = 2'b00; dm_signed = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      if_addr   = vecs[i].addr;
      dm_addr   = vecs[i].addr;
      dm_we     = vecs[i].we;
      dm_len    = vecs[i].len;
      dm_signed = vecs[i].sgn;
      dm_wdata  = vecs[i].wdata;
      if_req    = vecs[i].is_if;
      dm_req    = !vecs[i].is_if;
      do_txn(i, vecs[i].is_if, vecs[i].e_we, vecs[i].e_len, vecs[i].e_sgn, vecs[i].addr,
             vecs[i].e_wdata, vecs[i].delay, vecs[i].ack, vecs[i].e_rdata, vecs[i].e_berr,
             vecs[i].e_waits);
    end

    // bus_error is sticky and mem_ack in IDLE does nothing.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk1("idle ack rvalid", if_rvalid | dm_rvalid, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk1("bus_error sticky", bus_error, 1'b1);

    // Reset during WAIT_DM, then an ack right after release.
    dm_addr = 32'h4000; dm_we = 1'b0; dm_len = 2'b11; dm_signed = 1'b0; dm_wdata = 32'h0;
    dm_req = 1'b1;
    tick();
    chk1("rst dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    tick();
    chk1("rst in wait", mem_req, 1'b1);
    SYS_reset_n = 1'b0;
    tick();
    check_all_zero("midreset");
    SYS_reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0;
    chk1("post-reset dm_rvalid", dm_rvalid, 1'b0);
    chk1("post-reset mem_req", mem_req, 1'b0);
    chk("post-reset dm_rdata", dm_rdata, 32'h0);
    tick();
    chk1("post-reset dm_rvalid2", dm_rvalid, 1'b0);
    dm_addr = 32'h4004;
    dm_req  = 1'b1;
    do_txn(20, 1'b0, 1'b0, 2'b11, 1'b0, 32'h4004, 32'h0, 1, 32'h600DF00D, 32'h600DF00D, 1'b0, 2);

    // Simultaneous requests: data first, then the held fetch.
    if_addr = 32'h100; if_req = 1'b1;
    dm_addr = 32'h2000; dm_we = 1'b0; dm_len = 2'b11; dm_req = 1'b1;
    do_txn(30, 1'b0, 1'b0, 2'b11, 1'b0, 32'h2000, 32'h0, 2, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 3);
    do_txn(31, 1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1);

    // Starvation guard: four data grants, one fetch, then data again.
    for (int i = 0; i < 6; i++) begin
      if_addr = 32'h500 + 32'(i * 4);
      dm_addr = 32'h6000 + 32'(i * 4);
      if_req  = 1'b1;
      dm_req  = 1'b1;
      do_txn(40 + i, (i == 4), 1'b0, 2'b11, 1'b0, (i == 4) ? if_addr : dm_addr, 32'h0, 0,
             32'h1000 + 32'(i), 32'h1000 + 32'(i), 1'b0, 1);
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // Randomized traffic against the arbitration/completion rules.
    do_reset();
    if_pend = 1'b0; dm_pend = 1'b0; streak_m = 0;
    m_if_rdata = 32'h0; m_dm_rdata = 32'h0; m_berr = 1'b0;
    for (int it = 0; it < 150; it++) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) begin
        if_pend = 1'b1;
        if_addr = $urandom;
      end
      if (!dm_pend && ($urandom_range(0, 1) == 1)) begin
        dm_pend   = 1'b1;
        dm_we     = 1'($urandom_range(0, 1));
        dm_len    = 2'($urandom_range(1, 3));
        dm_signed = 1'($urandom_range(0, 1));
        dm_addr   = $urandom;
        dm_wdata  = $urandom;
      end
      if_req = if_pend;
      dm_req = dm_pend;
      if (!if_pend && !dm_pend) begin
        tick();
        chk1($sformatf("r%0d idle mem_req", it), mem_req, 1'b0);
        chk1($sformatf("r%0d idle gnt", it), if_gnt | dm_gnt, 1'b0);
        continue;
      end
      win_if = if_pend && (!dm_pend || streak_m == LIMIT);
      r = $urandom_range(0, 9);
      if (r <= 6)      delay = r % 4;
      else if (r <= 8) delay = TMO - 1;
      else             delay = -1;
      tmo = (delay < 0);
      ack = $urandom;
      if (win_if) e_rdata = tmo ? 32'h0 : ack;
      else        e_rdata = (tmo || dm_we) ? 32'h0 : ack;
      m_berr = m_berr | tmo;
      if (win_if) begin
        do_txn(100 + it, 1'b1, 1'b0, 2'b11, 1'b0, if_addr, 32'h0, delay, ack, e_rdata, m_berr,
               tmo ? TMO : delay + 1);
        streak_m   = 0;
        if_pend    = 1'b0;
        m_if_rdata = e_rdata;
        chk($sformatf("r%0d dm_rdata held", it), dm_rdata, m_dm_rdata);
      end else begin
        do_txn(100 + it, 1'b0, dm_we, dm_len, dm_signed, dm_addr, dm_wdata, delay, ack, e_rdata,
               m_berr, tmo ? TMO : delay + 1);
        streak_m   = (streak_m < LIMIT) ? streak_m + 1 : LIMIT;
        dm_pend    = 1'b0;
        m_dm_rdata = e_rdata;
        chk($sformatf("r%0d if_rdata held", it), if_rdata, m_if_rdata);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
